dds_quad_ref: RTL and testbench
===============================

# dds_quad_ref

Quadrature reference generator for the coherent phase-tracking loop. It runs a 32-bit phase accumulator from a frequency word, adds a programmable phase offset, and outputs matched signed 14-bit sine and cosine. These drive the multiplier/lag-filter stage that mixes the ADC stream. That stage's 32-bit phase-correction output feeds back into `phase_off`, which closes the loop.

## Interface
- `PHASE_W`, 32: accumulator, frequency-word and offset width.
- `LUT_AW`, 10: quarter-wave ROM address bits (1024 entries).
- `OUT_W`, 14: sine/cosine output width, two's complement.

Ports:
- `clk` in 1: system clock (100 MHz; `fre_word` 4294967 gives 100 kHz).
- `rst_n` in 1: reset, asynchronous, active-low; clock `clk`.
- `en` in 1: accumulator advance enable.
- `fre_word` in PHASE_W: frequency tuning word, unsigned.
- `fre_load` in 1: single-cycle strobe that captures `fre_word`.
- `phase_off` in PHASE_W: phase offset, sampled every cycle.
- `sin` out OUT_W: sine sample, signed.
- `cos` out OUT_W: cosine sample, signed.
- `valid` out 1: the output sample is derived from an enabled accumulator step.
- `wrap` out 1: one-cycle pulse, aligned with the first output sample after the accumulator overflows.

## Operation
- `fre_act` register:
  - Reset value 0.
  - Loaded from `fre_word` on any cycle where `fre_load`=1.
- `acc`:
  - Reset value 0.
  - When `en`=1, `acc <= acc + fre_act`, modulo 2^PHASE_W.
  - When `en`=0, `acc` holds.
- Carry out of the `acc` add feeds `wrap_p`.
- Stage 1:
  - `p <= acc + phase_off`, modulo 2^PHASE_W.
  - `pc <= acc + phase_off + 2^(PHASE_W-2)`, which is the +90° phase for cosine.
- Quarter-wave mapping, per path:
  - `q` = top 2 bits; `idx` = next LUT_AW bits.
  - If `q[0]`=1, `addr = ~idx`; otherwise `addr = idx`.
- Stage 2: registered ROM read. Entry k = round(8191·sin(π/2·(k+0.5)/1024)).
  - Range 6…8191. The half-LSB offset makes the mirror exact.
- Stage 3: if `q[1]`=1, the output is the negated ROM value; otherwise the ROM value.
  - Output range is ±8191; −8192 never appears.
- `valid` and `wrap` travel through a 3-deep shift pipeline alongside the data.
- Boundary conditions:
  - `fre_load` and `en` in the same cycle: that cycle's increment uses the old `fre_act`. The new word applies from the next cycle.
  - `fre_word`=0: `acc` is frozen, so output is constant and `wrap` never fires.
  - `phase_off` changes take effect on the next stage-1 capture, with no glitch.
  - Reset mid-operation: all registers clear asynchronously. Outputs read 0 and `valid`/`wrap` read 0 until the pipeline refills.

## Timing
- Latency from the `acc` register to `sin`/`cos` is 3 cycles. Throughput is 1 sample per cycle.
- `valid` rises 3 cycles after the first enabled cycle and falls 3 cycles after `en` drops.
- `sin` and `cos` always come from the same `acc` value, with no skew between them.
- Reset values of every output: `sin`=0, `cos`=0, `valid`=0, `wrap`=0.

## Configuration
- `DDS_DITHER_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1) advances every cycle.
  - Its value is added into the bits of `p`/`pc` below the LUT index, before truncation.
  - `acc` is untouched, so the mean frequency stays exact.
  - The LFSR resets to the seed.
- `DDS_DITHER_EN` undefined: plain truncation; the LFSR logic is absent.

## Structure
- Package `dds_pkg`:
  - Width constants.
  - Quadrant type.
  - LFSR taps and seed.
  - Constant function that builds the quarter-wave ROM contents.
- Sub-module `dds_quarter_rom`: dual read port, registered outputs, one instance shared by the sine and cosine paths.

## Test plan
- Reset held, then released with `en`=0 → `sin`=`cos`=0, `valid`=`wrap`=0 for every cycle.
- `fre_word`=0 loaded, `phase_off`=0, `en`=1 → 3 cycles later `sin`=6, `cos`=8191, `valid`=1, steady.
- `fre_word`=0, `phase_off`=0x4000_0000 → `sin`=8191, `cos`=−6.
- `fre_word`=0x0100_0000 → `wrap` pulses every 256 cycles. `sin` peaks at 8191 and troughs at −8191, and sin²+cos² stays within 1% of 8191².
- Load 0x0200_0000 mid-run with `en`=1 → `acc` delta is 0x0100_0000 in the load cycle and 0x0200_0000 thereafter; `wrap` period becomes 128.
- Drop `en` → `valid` falls 3 cycles later and outputs hold. Assert `rst_n` mid-run → all outputs are 0 within the same cycle.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared widths, quadrant type, dither LFSR constants and the quarter-wave ROM image builder.
package dds_pkg;
  localparam int PHASE_W   = 32;
  localparam int LUT_AW    = 10;
  localparam int OUT_W     = 14;
  localparam int ROM_DW    = OUT_W - 1;
  localparam int LUT_DEPTH = 1 << LUT_AW;
  localparam int OUT_MAX   = (1 << (OUT_W - 1)) - 1;

  localparam logic [PHASE_W-1:0] QUARTER_TURN = {2'b01, {(PHASE_W-2){1'b0}}};

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int          DITHER_SH = PHASE_W - 2 - LUT_AW - LFSR_W;

  typedef enum logic [1:0] {QUAD_0, QUAD_1, QUAD_2, QUAD_3} quad_t;
  typedef logic [LUT_AW-1:0] rom_addr_t;
  typedef logic [ROM_DW-1:0] rom_dat_t;

  function automatic quad_t quad_of(input logic [PHASE_W-1:0] ph);
    return quad_t'(ph[PHASE_W-1 -: 2]);
  endfunction

  // Odd quadrants walk the quarter wave backwards.
  function automatic rom_addr_t fold_addr(input logic [PHASE_W-1:0] ph);
    rom_addr_t idx;
    idx = ph[PHASE_W-3 -: LUT_AW];
    return ph[PHASE_W-2] ? ~idx : idx;
  endfunction

  // Half-LSB phase offset per entry makes the mirrored address exact.
  function automatic logic [ROM_DW*LUT_DEPTH-1:0] build_rom();
    logic [ROM_DW*LUT_DEPTH-1:0] img;
    real ph;
    real amp;
    int  k;
    img = '0;
    for (int hi = 0; hi < 32; hi++) begin
      for (int lo = 0; lo < LUT_DEPTH / 32; lo++) begin
        k   = hi * (LUT_DEPTH / 32) + lo;
        ph  = 1.5707963267948966 * (real'(k) + 0.5) / real'(LUT_DEPTH);
        amp = real'(OUT_MAX) * $sin(ph);
        img[k*ROM_DW +: ROM_DW] = ROM_DW'($rtoi(amp + 0.5));
      end
    end
    return img;
  endfunction
endpackage

// File: rtl/dds_quad_ref_if.sv
// Control and sample bus of the quadrature reference generator.
interface dds_quad_ref_if import dds_pkg::*; ();
  logic                      en;
  logic [PHASE_W-1:0]        fre_word;
  logic                      fre_load;
  logic [PHASE_W-1:0]        phase_off;
  logic signed [OUT_W-1:0]   sin;
  logic signed [OUT_W-1:0]   cos;
  logic                      valid;
  logic                      wrap;

  modport master (output en, fre_word, fre_load, phase_off,
                  input  sin, cos, valid, wrap);
  modport slave  (input  en, fre_word, fre_load, phase_off,
                  output sin, cos, valid, wrap);
endinterface

// File: rtl/dds_quarter_rom.sv
// Quarter-wave sine ROM, two read ports with registered outputs; reads only when rd_en_i is high.
module dds_quarter_rom import dds_pkg::*; (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rd_en_i,
  input  rom_addr_t addr_a_i,
  input  rom_addr_t addr_b_i,
  output rom_dat_t  dat_a_o,
  output rom_dat_t  dat_b_o
);
  localparam logic [ROM_DW*LUT_DEPTH-1:0] ROM_IMG = build_rom();

  rom_dat_t dat_a_q, dat_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_a_q <= '0;
      dat_b_q <= '0;
    end else if (rd_en_i) begin
      dat_a_q <= ROM_IMG[addr_a_i*ROM_DW +: ROM_DW];
      dat_b_q <= ROM_IMG[addr_b_i*ROM_DW +: ROM_DW];
    end
  end

  assign dat_a_o = dat_a_q;
  assign dat_b_o = dat_b_q;
endmodule

// File: rtl/dds_quad_ref.sv
// Phase accumulator DDS with matched sine/cosine, 3-cycle latency; stages hold when their valid is low.
// Optional phase dither via DDS_DITHER_EN (16-bit LFSR into the bits below the LUT index).
module dds_quad_ref import dds_pkg::*; (
  input logic           clk,
  input logic           rst_n,
  dds_quad_ref_if.slave bus
);
  logic [PHASE_W-1:0]      fre_act_q, acc_q, acc_d;
  logic                    carry_d, wrap_p_q;
  logic [PHASE_W-1:0]      dither, p_d, pc_d, p_q, pc_q;
  logic                    s1_vld_q, s1_wrap_q, s2_vld_q, s2_wrap_q, vld_q, wrap_q;
  logic                    neg_s_q, neg_c_q;
  rom_addr_t               addr_s, addr_c;
  rom_dat_t                rom_s, rom_c;
  logic signed [OUT_W-1:0] mag_s, mag_c, sin_d, cos_d, sin_q, cos_q;

  assign {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, fre_act_q};

  // A carry is held until the next enabled capture so it tags the first post-wrap sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fre_act_q <= '0;
      acc_q     <= '0;
      wrap_p_q  <= 1'b0;
    end else begin
      if (bus.fre_load) fre_act_q <= bus.fre_word;
      if (bus.en) begin
        acc_q    <= acc_d;
        wrap_p_q <= carry_d;
      end
    end
  end

`ifdef DDS_DITHER_EN
  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign dither = {{(PHASE_W-LFSR_W-DITHER_SH){1'b0}}, lfsr_q, {DITHER_SH{1'b0}}};
`else
  assign dither = '0;
`endif

  assign p_d  = acc_q + bus.phase_off + dither;
  assign pc_d = p_d + QUARTER_TURN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q       <= '0;
      pc_q      <= '0;
      s1_vld_q  <= 1'b0;
      s1_wrap_q <= 1'b0;
    end else begin
      s1_vld_q  <= bus.en;
      s1_wrap_q <= bus.en & wrap_p_q;
      if (bus.en) begin
        p_q  <= p_d;
        pc_q <= pc_d;
      end
    end
  end

  assign addr_s = fold_addr(p_q);
  assign addr_c = fold_addr(pc_q);

  dds_quarter_rom u_rom (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en_i  (s1_vld_q),
    .addr_a_i (addr_s),
    .addr_b_i (addr_c),
    .dat_a_o  (rom_s),
    .dat_b_o  (rom_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_s_q   <= 1'b0;
      neg_c_q   <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_wrap_q <= 1'b0;
    end else begin
      s2_vld_q  <= s1_vld_q;
      s2_wrap_q <= s1_wrap_q;
      if (s1_vld_q) begin
        neg_s_q <= quad_of(p_q) inside {QUAD_2, QUAD_3};
        neg_c_q <= quad_of(pc_q) inside {QUAD_2, QUAD_3};
      end
    end
  end

  always_comb begin
    mag_s = {1'b0, rom_s};
    mag_c = {1'b0, rom_c};
    sin_d = neg_s_q ? -mag_s : mag_s;
    cos_d = neg_c_q ? -mag_c : mag_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_q  <= '0;
      cos_q  <= '0;
      vld_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      vld_q  <= s2_vld_q;
      wrap_q <= s2_wrap_q;
      if (s2_vld_q) begin
        sin_q <= sin_d;
        cos_q <= cos_d;
      end
    end
  end

  assign bus.sin   = sin_q;
  assign bus.cos   = cos_q;
  assign bus.valid = vld_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_dds_quad_ref.sv
// Directed bench for dds_quad_ref: reset, constant phase, load timing, sweep/wrap period, mid-run reset.
module tb_dds_quad_ref;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  dds_quad_ref_if bus();

  dds_quad_ref u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.fre_load = 1'b0; bus.fre_word = '0; bus.phase_off = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.sin !== 14'sd0) begin failures++; $display("FAIL reset_sin got=%0d exp=0", bus.sin); end
    checks++; if (bus.cos !== 14'sd0) begin failures++; $display("FAIL reset_cos got=%0d exp=0", bus.cos); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    checks++; if (bus.wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (bus.sin !== 14'sd0 || bus.cos !== 14'sd0 || bus.valid !== 1'b0 || bus.wrap !== 1'b0) begin
        failures++;
        $display("FAIL idle_en0 cyc=%0d got sin=%0d cos=%0d valid=%b wrap=%b exp all 0",
                 c, bus.sin, bus.cos, bus.valid, bus.wrap);
      end
    end
  endtask

  task automatic test_const_phase();
    bus.fre_word = '0; bus.fre_load = 1'b1; bus.phase_off = '0; bus.en = 1'b1;
    tick();
    bus.fre_load = 1'b0;
    tick();
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL latency_valid_early got=%b exp=0", bus.valid); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (bus.sin !== 14'sd6 || bus.cos !== 14'sd8191 || bus.valid !== 1'b1 || bus.wrap !== 1'b0) begin
        failures++;
        $display("FAIL phase0 cyc=%0d got sin=%0d cos=%0d valid=%b wrap=%b exp 6 8191 1 0",
                 c, bus.sin, bus.cos, bus.valid, bus.wrap);
      end
    end
    bus.phase_off = 32'h4000_0000;
    tick();
    tick();
    checks++; if (bus.sin !== 14'sd6) begin failures++; $display("FAIL phase_off_early got=%0d exp=6", bus.sin); end
    tick();
    checks++; if (bus.sin !== 14'sd8191) begin failures++; $display("FAIL phase90_sin got=%0d exp=8191", bus.sin); end
    checks++; if (bus.cos !== -14'sd6) begin failures++; $display("FAIL phase90_cos got=%0d exp=-6", bus.cos); end
    bus.phase_off = '0;
  endtask

  // Load and enable in the same cycle, then drop enable after six steps.
  task automatic test_load_same_cycle();
    int exp_vld [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int exp_sin [12] = '{0, 0, 6, 6, 8191, -6, -8191, 6, 6, 6, 6, 6};
    int exp_cos [12] = '{0, 0, 8191, 8191, -6, -8191, 6, 8191, 8191, 8191, 8191, 8191};
    int exp_wrp [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.en = 1'b1; bus.fre_word = 32'h4000_0000; bus.fre_load = 1'b1; bus.phase_off = '0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 1) bus.fre_load = 1'b0;
      if (t == 6) bus.en = 1'b0;
      checks++;
      if (bus.valid !== 1'(exp_vld[t-1]) || bus.sin !== 14'(exp_sin[t-1]) ||
          bus.cos !== 14'(exp_cos[t-1]) || bus.wrap !== 1'(exp_wrp[t-1])) begin
        failures++;
        $display("FAIL load_seq t=%0d got sin=%0d cos=%0d valid=%b wrap=%b exp sin=%0d cos=%0d valid=%0d wrap=%0d",
                 t, bus.sin, bus.cos, bus.valid, bus.wrap, exp_sin[t-1], exp_cos[t-1], exp_vld[t-1], exp_wrp[t-1]);
      end
    end
  endtask

  task automatic test_sweep();
    int     wt[$];
    int     smax, smin, cmax, cmin;
    longint m;
    smax = -100000; smin = 100000; cmax = -100000; cmin = 100000;
    bus.fre_word = 32'h0100_0000; bus.fre_load = 1'b1; bus.en = 1'b1;
    tick();
    bus.fre_load = 1'b0;
    for (int c = 0; c < 800; c++) begin
      tick();
      if (bus.wrap === 1'b1) wt.push_back(c);
      if (bus.valid === 1'b1) begin
        if (int'(bus.sin) > smax) smax = int'(bus.sin);
        if (int'(bus.sin) < smin) smin = int'(bus.sin);
        if (int'(bus.cos) > cmax) cmax = int'(bus.cos);
        if (int'(bus.cos) < cmin) cmin = int'(bus.cos);
        m = longint'(bus.sin) * longint'(bus.sin) + longint'(bus.cos) * longint'(bus.cos);
        checks++;
        if (m < 64'sd66421557 || m > 64'sd67763405) begin
          failures++;
          $display("FAIL magnitude cyc=%0d got=%0d exp within 66421557..67763405", c, m);
        end
      end
    end
    checks++; if (wt.size() < 3) begin failures++; $display("FAIL wrap_count_256 got=%0d exp>=3", wt.size()); end
    for (int i = 1; i < wt.size(); i++) begin
      checks++;
      if (wt[i] - wt[i-1] != 256) begin failures++; $display("FAIL wrap_period_256 got=%0d exp=256", wt[i] - wt[i-1]); end
    end
    checks++; if (smax != 8191) begin failures++; $display("FAIL sin_peak got=%0d exp=8191", smax); end
    checks++; if (smin != -8191) begin failures++; $display("FAIL sin_trough got=%0d exp=-8191", smin); end
    checks++; if (cmax != 8191) begin failures++; $display("FAIL cos_peak got=%0d exp=8191", cmax); end
    checks++; if (cmin != -8191) begin failures++; $display("FAIL cos_trough got=%0d exp=-8191", cmin); end

    wt.delete();
    bus.fre_word = 32'h0200_0000; bus.fre_load = 1'b1;
    tick();
    bus.fre_load = 1'b0;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (c >= 6 && bus.wrap === 1'b1) wt.push_back(c);
    end
    checks++; if (wt.size() < 3) begin failures++; $display("FAIL wrap_count_128 got=%0d exp>=3", wt.size()); end
    for (int i = 1; i < wt.size(); i++) begin
      checks++;
      if (wt[i] - wt[i-1] != 128) begin failures++; $display("FAIL wrap_period_128 got=%0d exp=128", wt[i] - wt[i-1]); end
    end
  endtask

  task automatic test_reset_midrun();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sin !== 14'sd0 || bus.cos !== 14'sd0 || bus.valid !== 1'b0 || bus.wrap !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset got sin=%0d cos=%0d valid=%b wrap=%b exp all 0", bus.sin, bus.cos, bus.valid, bus.wrap);
    end
    tick();
    rst_n = 1'b1;
    bus.en = 1'b1; bus.fre_load = 1'b0; bus.phase_off = '0;
    tick();
    tick();
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL refill_valid_early got=%b exp=0", bus.valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.sin !== 14'sd6 || bus.cos !== 14'sd8191 || bus.valid !== 1'b1 || bus.wrap !== 1'b0) begin
        failures++;
        $display("FAIL refill cyc=%0d got sin=%0d cos=%0d valid=%b wrap=%b exp 6 8191 1 0",
                 c, bus.sin, bus.cos, bus.valid, bus.wrap);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_const_phase();
    test_load_same_cycle();
    test_sweep();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
